mult_datapath_param: RTL
========================

Name: mult_datapath_param

Overview:
- Parametrised successor to the fixed 8-bit multiplier datapath: a sequential shift-add multiplier with operand-entry handshake, signed/unsigned mode and a parametrised hex 7-segment display bank.
- Accepts operand A, then operand B, from switch data on debounced `enter` presses.
- Computes the product over WIDTH cycles and holds it on the displays until the next operation.
- Sits between the board I/O (switches, key, HEX displays) and the top level.

Parameters:
- WIDTH, 8: operand width; must be even, 4..16.
- SIGNED_EN, 1: 1 enables two's-complement mode via `signed_mode`; 0 forces unsigned.
- Derived localparam NDIG = WIDTH/2: number of hex digits (2*WIDTH-bit product).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enter  in  1  debounced key level; block does its own rising-edge detect
- inputdata  in  WIDTH  operand value from switches
- loaddata  in  1  1 = this press loads an operand; 0 = this press cancels
- signed_mode  in  1  1 = two's-complement operands (ignored if SIGNED_EN=0)
- inputdata_ready  out  1  block accepts an operand this cycle (IDLE, WAIT_B, DONE)
- busy  out  1  high in MULT
- done  out  1  high in DONE
- product  out  2*WIDTH  result register
- disp  out  7*NDIG  active-low segments; digit i at bits [7i+6:7i], bit order g..a; digit 0 = least-significant nibble

Behaviour:
- Synchronous, active-high reset, one clk domain:
  - reset high at an edge → state IDLE, enter_q=0, A=B=0, product=0, count=0.
  - Outputs: inputdata_ready=1, busy=0, done=0.
  - disp shows inputdata (IDLE rule).
  - Reset mid-MULT aborts the operation; there is no partial result.
- Edge detect: press = enter & ~enter_q, with enter_q registered every cycle.
  - Holding enter high yields exactly one press.
  - A press is acted on at the same edge at which enter is first sampled high.
- FSM:
  - IDLE: press & loaddata → A := inputdata, latch sign mode → WAIT_B. Press & !loaddata → stay.
  - WAIT_B: press & loaddata → B := inputdata → MULT, count := 0. Press & !loaddata → IDLE (cancel, A cleared).
  - MULT: one shift-add iteration per cycle, WIDTH iterations. Presses are ignored. After the iteration with count = WIDTH-1 → DONE.
  - DONE: product held. Press & loaddata → A := inputdata → WAIT_B (new operation). Press & !loaddata → IDLE; product is retained, but disp returns to live input.
- Latency: B capture at edge E0; iterations at E1..E_WIDTH; done=1 and product valid from E_WIDTH.
- Arithmetic:
  - Unsigned: 2*WIDTH-bit accumulator; add multiplicand << i when multiplier bit i = 1.
  - Signed: multiply magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH bits unsigned). Negate at the final iteration if the operand signs differ.
  - Result is an exact 2*WIDTH-bit two's-complement value; no overflow is possible.
  - Mode is latched at A capture; changes to signed_mode afterwards do not affect the current operation.
- Display:
  - DONE: product nibbles.
  - All other states: inputdata zero-extended to 2*WIDTH, nibbles.
  - Registered one cycle after the source changes.
- Operand 0 still takes the full WIDTH cycles; there is no early termination.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (IDLE, WAIT_B, MULT, DONE);
  - the 16-entry active-low 7-segment constant table.
- Sub-module hex7seg: 4-bit nibble → 7-bit active-low segments, combinational. Instantiated NDIG times with a generate loop.
- FSM, edge detect and shift-add live in this module.

Test Plan:
- Unsigned, WIDTH=8: A=13, B=11 → busy for 8 cycles after the B edge; product=0x008F; done=1; disp digits 3..0 = 0,0,8,F (0x40,0x40,0x00,0x0E).
- Signed: A=0xFD (-3), B=0x05 → product=0xFFF1 (-15). Also A=0x80, B=0x80 → 0x4000.
- Unsigned A=0xFF, B=0xFF → 0xFE01. The same operands in signed mode → 0x0001.
- Enter held high for 20 cycles in IDLE → only A is captured; a press during MULT does not change the result or the state.
- WAIT_B press with loaddata=0 → IDLE, A=0. Reset asserted at MULT iteration 4 → next edge: IDLE, product=0, busy=0, inputdata_ready=1.
- WIDTH=4 instance: A=0x7, B=0x9, unsigned → 0x3F after 4 cycles, on NDIG=2 digits.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and active-low hex 7-segment table (bit order g..a)
package mult_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_B, MULT, DONE} state_t;
  localparam logic [15:0][6:0] SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble -> active-low segments; nibble in, seg[6:0] (g..a) out
module hex7seg
  import mult_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG7[nibble];
endmodule

// File: rtl/mult_datapath_param.sv
// mult_datapath_param: shift-add multiplier with enter handshake and hex display; clk/reset, enter/inputdata/loaddata/signed_mode in, inputdata_ready/busy/done/product/disp out
module mult_datapath_param
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enter,
  input  logic [WIDTH-1:0]       inputdata,
  input  logic                   loaddata,
  input  logic                   signed_mode,
  output logic                   inputdata_ready,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [7*(WIDTH/2)-1:0] disp
);
  localparam int NDIG = WIDTH / 2;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic enter_q, press, sgn, neg, last;
  logic [WIDTH-1:0] a, b, mag_a, mag_b;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] sum, src;
  logic [7*NDIG-1:0] segs;
  assign press = enter & ~enter_q;
  assign mag_a = sgn && a[WIDTH-1] ? -a : a;
  assign mag_b = sgn && b[WIDTH-1] ? -b : b;
  assign neg = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign last = count == CW'(WIDTH - 1);
  assign sum = product + (mag_b[count] ? ({{WIDTH{1'b0}}, mag_a} << count) : '0);
  assign inputdata_ready = state != MULT;
  assign busy = state == MULT;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = press && loaddata ? WAIT_B : IDLE;
      WAIT_B: state_n = press ? (loaddata ? MULT : IDLE) : WAIT_B;
      MULT:   state_n = last ? DONE : MULT;
      DONE:   state_n = press ? (loaddata ? WAIT_B : IDLE) : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q <= 1'b0;
      a       <= '0;
      b       <= '0;
      product <= '0;
      count   <= '0;
      sgn     <= 1'b0;
    end else begin
      enter_q <= enter;
      if (press && loaddata && (state == IDLE || state == DONE)) begin
        a   <= inputdata;
        sgn <= SIGNED_EN && signed_mode;
      end
      if (press && state == WAIT_B) begin
        if (loaddata) begin
          b       <= inputdata;
          product <= '0;
          count   <= '0;
        end else a <= '0;
      end
      if (state == MULT) begin
        count   <= count + 1'b1;
        product <= last && neg ? -sum : sum;
      end
    end
  end
  assign src = state == DONE && !reset ? product : {{WIDTH{1'b0}}, inputdata};
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    hex7seg u_hex (.nibble(src[4*i+:4]), .seg(segs[7*i+:7]));
  end
  always_ff @(posedge clk) disp <= segs;
endmodule
